// File: rtl/time_set_ctrl.sv
// time_set_ctrl: debounced MODE/INC keys drive HH:MM:SS field editing with load pulse and blink mask.
// Optional TIME_SET_AUTO_REPEAT_EN: holding INC auto-repeats increments in set mode.
module time_set_ctrl #(
  parameter int CLOCK_FREQ  = 50000000,
  parameter int DEBOUNCE_MS = 20,
  parameter int BLINK_HALF  = CLOCK_FREQ/4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_key_mode_n,
  input  logic        i_key_inc_n,
  input  logic [23:0] i_cur_time,
  output logic [23:0] o_time,
  output logic        o_load,
  output logic        o_set_active,
  output logic [5:0]  o_blink
);
  localparam int DB = (CLOCK_FREQ/1000)*DEBOUNCE_MS;
  localparam int DW = $clog2(DB+1);
  localparam int BW = $clog2(BLINK_HALF+1);
  typedef enum logic [1:0] {RUN, SET_HR, SET_MIN, SET_SEC} state_t;
  logic [1:0] raw, db, dbp, ev;
  logic       mode_ev, inc_ev, inc;
  state_t     state_q, state_d;
  logic [23:0] time_d;
  logic        phase_q, phase_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [5:0]  mask_d;
  assign raw = {i_key_mode_n, i_key_inc_n};
  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_key
      logic s1_q, s2_q, db_q, dbp_q;
      logic [DW-1:0] cnt_q;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          s1_q  <= 1'b1;
          s2_q  <= 1'b1;
          db_q  <= 1'b1;
          dbp_q <= 1'b1;
          cnt_q <= '0;
        end else begin
          s1_q  <= raw[g];
          s2_q  <= s1_q;
          dbp_q <= db_q;
          if (s2_q == db_q) cnt_q <= '0;
          else if (cnt_q == DW'(DB-1)) begin
            cnt_q <= '0;
            db_q  <= s2_q;
          end else cnt_q <= cnt_q + 1'b1;
        end
      assign db[g]  = db_q;
      assign dbp[g] = dbp_q;
    end
  endgenerate
  assign ev      = dbp & ~db;
  assign mode_ev = ev[1];
`ifdef TIME_SET_AUTO_REPEAT_EN
  localparam int HW = $clog2(CLOCK_FREQ+1);
  logic [HW-1:0] hold_q;
  logic          rep;
  assign rep = hold_q == HW'(CLOCK_FREQ-1);
  // After the first 1 s, rewind so each further repeat lands 200 ms later
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) hold_q <= '0;
    else if (db[0] || mode_ev || state_q == RUN) hold_q <= '0;
    else if (rep) hold_q <= HW'(CLOCK_FREQ - CLOCK_FREQ/5);
    else hold_q <= hold_q + 1'b1;
  assign inc_ev = ev[0] | rep;
`else
  assign inc_ev = ev[0];
`endif
  // Invalid BCD or value at/above the field max restarts the field at 00
  function automatic logic [7:0] bump(input logic [7:0] v, input logic [7:0] max);
    bump = (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v >= max) ? 8'h00 :
           (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'h0} : v + 8'd1;
  endfunction
  always_comb begin
    state_d = state_q;
    time_d  = o_time;
    phase_d = phase_q;
    bcnt_d  = bcnt_q;
    inc     = inc_ev && !mode_ev && state_q != RUN;
    if (mode_ev) begin
      state_d = state_q == RUN ? SET_HR : state_q == SET_HR ? SET_MIN :
                state_q == SET_MIN ? SET_SEC : RUN;
      time_d  = state_q == RUN ? i_cur_time : o_time;
      phase_d = 1'b0;
      bcnt_d  = '0;
    end else if (inc) begin
      time_d[23:16] = state_q == SET_HR  ? bump(o_time[23:16], 8'h23) : o_time[23:16];
      time_d[15:8]  = state_q == SET_MIN ? bump(o_time[15:8], 8'h59)  : o_time[15:8];
      time_d[7:0]   = state_q == SET_SEC ? bump(o_time[7:0], 8'h59)   : o_time[7:0];
      phase_d = 1'b0;
      bcnt_d  = '0;
    end else if (state_q != RUN) begin
      phase_d = bcnt_q == BW'(BLINK_HALF-1) ? ~phase_q : phase_q;
      bcnt_d  = bcnt_q == BW'(BLINK_HALF-1) ? '0 : bcnt_q + 1'b1;
    end
    mask_d = !phase_d ? 6'b0 : state_d == SET_HR ? 6'b110000 :
             state_d == SET_MIN ? 6'b001100 : state_d == SET_SEC ? 6'b000011 : 6'b0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= RUN;
      o_time       <= '0;
      phase_q      <= 1'b0;
      bcnt_q       <= '0;
      o_load       <= 1'b0;
      o_set_active <= 1'b0;
      o_blink      <= '0;
    end else begin
      state_q      <= state_d;
      o_time       <= time_d;
      phase_q      <= phase_d;
      bcnt_q       <= bcnt_d;
      o_load       <= mode_ev && state_q == SET_SEC;
      o_set_active <= state_d != RUN;
      o_blink      <= mask_d;
    end
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed vectors for time_set_ctrl with 50-cycle debounce and 12500-cycle blink.
module tb_time_set_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_mode_n = 1'b1;
  logic        key_inc_n = 1'b1;
  logic [23:0] cur_time = 24'h235958;
  logic [23:0] o_time;
  logic        o_load, o_set_active;
  logic [5:0]  o_blink;
  int          checks = 0, errors = 0, load_cnt = 0;
  logic [23:0] load_time = '0;
  time_set_ctrl #(.CLOCK_FREQ(50000), .DEBOUNCE_MS(1)) dut (
    .clk(clk), .rst_n(rst_n), .i_key_mode_n(key_mode_n), .i_key_inc_n(key_inc_n),
    .i_cur_time(cur_time), .o_time(o_time), .o_load(o_load),
    .o_set_active(o_set_active), .o_blink(o_blink)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      if (o_load) begin
        load_cnt++;
        load_time = o_time;
      end
    end
  endtask
  task automatic press(input logic m, input logic i);
    @(negedge clk);
    key_mode_n = ~m;
    key_inc_n  = ~i;
    idle(100);
    key_mode_n = 1'b1;
    key_inc_n  = 1'b1;
    idle(100);
  endtask
  task automatic wait_blink_on(input string tag, input logic [5:0] exp);
    int n = 0;
    while (o_blink == 6'b0 && n < 13000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {26'b0, o_blink}, {26'b0, exp});
  endtask
  initial begin
    int n;
    idle(5);
    chk("rst_time", o_time, 24'h000000);
    chk("rst_flags", {o_load, o_set_active, o_blink}, 8'h00);
    rst_n = 1'b1;
    idle(20);
    chk("post_rst_time", o_time, 24'h000000);
    chk("post_rst_flags", {o_load, o_set_active, o_blink}, 8'h00);
    press(1, 0);
    chk("capture", o_time, 24'h235958);
    chk("set_active", o_set_active, 1);
    chk("blink_off_first", o_blink, 6'b0);
    wait_blink_on("blink_hr", 6'b110000);
    n = 0;
    while (o_blink != 6'b0 && n < 13000) begin
      @(negedge clk);
      n++;
    end
    chk("blink_half", n, 12500);
    @(negedge clk);
    for (int b = 0; b < 5; b++) begin
      key_inc_n = 1'b0;
      idle(3);
      key_inc_n = 1'b1;
      idle(3);
    end
    press(0, 1);
    chk("hr_wrap", o_time, 24'h005958);
    press(1, 0);
    press(0, 1);
    chk("min_wrap", o_time, 24'h000058);
    press(1, 0);
    press(0, 1);
    chk("sec_inc", o_time, 24'h000059);
    press(0, 1);
    chk("sec_wrap", o_time, 24'h000000);
    chk("no_early_load", load_cnt, 0);
    press(1, 0);
    chk("load_once", load_cnt, 1);
    chk("load_time", load_time, 24'h000000);
    chk("run_inactive", o_set_active, 0);
    cur_time = 24'h123456;
    press(0, 1);
    chk("run_hold", o_time, 24'h000000);
    cur_time = 24'h2F3456;
    press(1, 0);
    chk("capture_bad", o_time, 24'h2F3456);
    press(1, 1);
    chk("mode_wins", o_time, 24'h2F3456);
    press(0, 1);
    chk("in_min", o_time, 24'h2F3556);
    wait_blink_on("blink_min", 6'b001100);
    load_cnt = 0;
    rst_n = 1'b0;
    #1;
    chk("midrst_active", o_set_active, 0);
    chk("midrst_time", o_time, 24'h000000);
    chk("midrst_blink", o_blink, 6'b0);
    idle(5);
    rst_n = 1'b1;
    idle(20);
    chk("midrst_noload", load_cnt, 0);
    press(1, 0);
    chk("recapture", o_time, 24'h2F3456);
    press(0, 1);
    chk("bad_hr_inc", o_time, 24'h003456);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
